// File: rtl/gc_block_manager_if.sv
// rtl/gc_block_manager_if.sv - handshake bundle between the FTL and gc_block_manager
// Ports (as signals of the bundle):
//   master : FTL side; drives alloc_req, invalid_en/invalid_blk, gc_start, move_done, erase_ack
//   slave  : gc_block_manager; drives alloc_grant/alloc_blk/active_blk, move_req/move_blk/
//            move_valid_pages, erase_req/erase_blk, free_count, init_done, gc_busy, inv_err
interface gc_block_manager_if #(
   parameter int BLOCK_NUM       = 1024,
   parameter int PAGES_PER_BLOCK = 64
);
   localparam int BLK_W = $clog2(BLOCK_NUM);
   localparam int PG_W  = $clog2(PAGES_PER_BLOCK + 1);
   localparam int CNT_W = BLK_W + 1;

   logic             alloc_req;
   logic             alloc_grant;
   logic [BLK_W-1:0] alloc_blk;
   logic [BLK_W-1:0] active_blk;
   logic             invalid_en;
   logic [BLK_W-1:0] invalid_blk;
   logic             gc_start;
   logic             move_req;
   logic [BLK_W-1:0] move_blk;
   logic [PG_W-1:0]  move_valid_pages;
   logic             move_done;
   logic             erase_req;
   logic [BLK_W-1:0] erase_blk;
   logic             erase_ack;
   logic [CNT_W-1:0] free_count;
   logic             init_done;
   logic             gc_busy;
   logic             inv_err;

   modport master (
      output alloc_req, invalid_en, invalid_blk, gc_start, move_done, erase_ack,
      input  alloc_grant, alloc_blk, active_blk, move_req, move_blk, move_valid_pages,
             erase_req, erase_blk, free_count, init_done, gc_busy, inv_err
   );

   modport slave (
      input  alloc_req, invalid_en, invalid_blk, gc_start, move_done, erase_ack,
      output alloc_grant, alloc_blk, active_blk, move_req, move_blk, move_valid_pages,
             erase_req, erase_blk, free_count, init_done, gc_busy, inv_err
   );
endinterface

// File: rtl/gc_block_manager.sv
// rtl/gc_block_manager.sv - free-block FIFO, invalid-page tracking and GC sequencer
// Ports:
//   CLK  : clock, all state changes on the rising edge
//   RST  : synchronous active-high reset
//   bus  : gc_block_manager_if.slave
//          allocation   - alloc_req in, alloc_grant/alloc_blk/active_blk out
//          invalidation - invalid_en/invalid_blk in, inv_err out (sticky)
//          GC handshake - gc_start in, move_req/move_blk/move_valid_pages out, move_done in,
//                         erase_req/erase_blk out, erase_ack in
//          status       - free_count, init_done, gc_busy out
module gc_block_manager #(
   parameter int BLOCK_NUM       = 1024,
   parameter int PAGES_PER_BLOCK = 64,
   parameter int GC_THRESHOLD    = 4
) (
   input logic              CLK,
   input logic              RST,
   gc_block_manager_if.slave bus
);
   localparam int BLK_W = $clog2(BLOCK_NUM);
   localparam int PG_W  = $clog2(PAGES_PER_BLOCK + 1);
   localparam int CNT_W = BLK_W + 1;

   localparam logic [BLK_W-1:0] LAST_IDX = BLK_W'(BLOCK_NUM - 1);
   localparam logic [PG_W-1:0]  PAGES    = PG_W'(PAGES_PER_BLOCK);
   localparam logic [CNT_W-1:0] GC_TH    = CNT_W'(GC_THRESHOLD);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_SCAN,
      S_MOVE,
      S_ERASE,
      S_RECLAIM
   } state_t;

   state_t state;

   // Free-block FIFO storage and pointers
   logic [BLK_W-1:0] fifo_mem [BLOCK_NUM];
   logic [BLK_W-1:0] head;
   logic [BLK_W-1:0] tail;
   logic [CNT_W-1:0] free_count;

   // Per-block state
   logic [PG_W-1:0]      inv_cnt [BLOCK_NUM];
   logic [BLOCK_NUM-1:0] alloc_bit;

   // idx walks 0..BLOCK_NUM-1 in INIT (push index) and again in SCAN (examined index)
   logic [BLK_W-1:0] idx;
   logic [PG_W-1:0]  best_cnt;
   logic [BLK_W-1:0] best_idx;

   logic             armed;
   logic             init_done;
   logic             move_req;
   logic             erase_req;
   logic             gc_busy;
   logic             inv_err;
   logic [BLK_W-1:0] active_blk;
   logic [BLK_W-1:0] victim;
   logic [PG_W-1:0]  move_valid_pages;

   logic             grant;
   logic             push;
   logic [BLK_W-1:0] push_data;
   logic [BLK_W-1:0] head_blk;
   logic             inv_accept;
   logic             cand;
   logic [PG_W-1:0]  scan_best_cnt;
   logic [BLK_W-1:0] scan_best_idx;

   assign head_blk   = fifo_mem[head];
   assign grant      = bus.alloc_req && init_done && (free_count != '0);
   assign push       = (state == S_INIT) || (state == S_RECLAIM);
   assign push_data  = (state == S_INIT) ? idx : victim;
   assign inv_accept = bus.invalid_en && alloc_bit[bus.invalid_blk];

   // Strict greater-than keeps the earliest (lowest) index on ties.
   assign cand          = alloc_bit[idx] && (idx != active_blk) && (inv_cnt[idx] > best_cnt);
   assign scan_best_cnt = cand ? inv_cnt[idx] : best_cnt;
   assign scan_best_idx = cand ? idx : best_idx;

   always_ff @(posedge CLK) begin
      if (!RST && push) begin
         fifo_mem[tail] <= push_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state            <= S_INIT;
         head             <= '0;
         tail             <= '0;
         free_count       <= '0;
         alloc_bit        <= '0;
         idx              <= '0;
         best_cnt         <= '0;
         best_idx         <= '0;
         armed            <= 1'b1;
         init_done        <= 1'b0;
         move_req         <= 1'b0;
         erase_req        <= 1'b0;
         gc_busy          <= 1'b0;
         inv_err          <= 1'b0;
         active_blk       <= '0;
         victim           <= '0;
         move_valid_pages <= '0;
         for (int i = 0; i < BLOCK_NUM; i++) begin
            inv_cnt[i] <= '0;
         end
      end else begin
         if (push) begin
            tail <= tail + 1'b1;
         end
         if (grant) begin
            head <= head + 1'b1;
         end
         case ({push, grant})
            2'b10:   free_count <= free_count + 1'b1;
            2'b01:   free_count <= free_count - 1'b1;
            default: free_count <= free_count;
         endcase

         if (bus.invalid_en) begin
            if (alloc_bit[bus.invalid_blk]) begin
               armed <= 1'b1;
               if (inv_cnt[bus.invalid_blk] != PAGES) begin
                  inv_cnt[bus.invalid_blk] <= inv_cnt[bus.invalid_blk] + 1'b1;
               end
            end else begin
               inv_err <= 1'b1;
            end
         end

         if (grant) begin
            alloc_bit[head_blk] <= 1'b1;
            active_blk          <= head_blk;
         end

         // FSM sits last so that RECLAIM clearing the victim overrides a same-cycle invalidate.
         case (state)
            S_INIT: begin
               idx <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  init_done <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (armed && ((free_count <= GC_TH) || bus.gc_start)) begin
                  state    <= S_SCAN;
                  gc_busy  <= 1'b1;
                  idx      <= '0;
                  best_cnt <= '0;
                  best_idx <= '0;
               end
            end
            S_SCAN: begin
               idx      <= idx + 1'b1;
               best_cnt <= scan_best_cnt;
               best_idx <= scan_best_idx;
               if (idx == LAST_IDX) begin
                  if (scan_best_cnt == '0) begin
                     // A fresh invalidate in this same cycle keeps GC armed.
                     if (!inv_accept) begin
                        armed <= 1'b0;
                     end
                     gc_busy <= 1'b0;
                     state   <= S_IDLE;
                  end else begin
                     victim           <= scan_best_idx;
                     move_valid_pages <= PAGES - inv_cnt[scan_best_idx];
                     move_req         <= 1'b1;
                     state            <= S_MOVE;
                  end
               end
            end
            S_MOVE: begin
               if (bus.move_done) begin
                  move_req  <= 1'b0;
                  erase_req <= 1'b1;
                  state     <= S_ERASE;
               end
            end
            S_ERASE: begin
               if (bus.erase_ack) begin
                  erase_req <= 1'b0;
                  state     <= S_RECLAIM;
               end
            end
            S_RECLAIM: begin
               alloc_bit[victim] <= 1'b0;
               inv_cnt[victim]   <= '0;
               gc_busy           <= 1'b0;
               state             <= S_IDLE;
            end
            default: begin
               state <= S_INIT;
            end
         endcase
      end
   end

   assign bus.alloc_grant      = grant;
   assign bus.alloc_blk        = (free_count != '0) ? head_blk : '0;
   assign bus.active_blk       = active_blk;
   assign bus.move_req         = move_req;
   assign bus.move_blk         = victim;
   assign bus.move_valid_pages = move_valid_pages;
   assign bus.erase_req        = erase_req;
   assign bus.erase_blk        = victim;
   assign bus.free_count       = free_count;
   assign bus.init_done        = init_done;
   assign bus.gc_busy          = gc_busy;
   assign bus.inv_err          = inv_err;
endmodule

// File: doc/gc_block_manager.md
# gc_block_manager

Parametrised free-block manager and garbage-collection sequencer for the NVM flash translation layer. It builds and maintains a circular free-block FIFO covering every physical block, serves block allocations to the write path, and tracks invalid-page counts per block. When free space runs low, it runs a deterministic scan for the most-invalidated victim and drives the relocate, erase and reclaim handshakes.

## Interface
- BLOCK_NUM, default 1024: number of physical blocks; must be a power of two and at least 4.
- PAGES_PER_BLOCK, default 64: pages per block.
- GC_THRESHOLD, default 4: GC triggers when free_count is at or below this value.
- Derived widths: BLK_W = $clog2(BLOCK_NUM); PG_W = $clog2(PAGES_PER_BLOCK+1); CNT_W = BLK_W+1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- alloc_req  in  1  write path requests a fresh block.
- alloc_grant  out  1  combinational; equals alloc_req && init_done && free_count!=0.
- alloc_blk  out  BLK_W  FIFO head; valid when free_count!=0.
- active_blk  out  BLK_W  last granted block.
- invalid_en  in  1  one page of invalid_blk became invalid this cycle.
- invalid_blk  in  BLK_W  block containing the invalidated page.
- gc_start  in  1  forces a GC attempt regardless of the threshold.
- move_req  out  1  relocate valid pages of move_blk; held until move_done.
- move_blk  out  BLK_W  victim block.
- move_valid_pages  out  PG_W  PAGES_PER_BLOCK minus the victim's invalid count, latched on MOVE entry.
- move_done  in  1  one-cycle pulse; relocation finished.
- erase_req  out  1  held until erase_ack.
- erase_blk  out  BLK_W  equals move_blk.
- erase_ack  in  1  one-cycle pulse; erase finished.
- free_count  out  CNT_W  number of entries in the free FIFO.
- init_done  out  1  free FIFO fully populated.
- gc_busy  out  1  FSM is not in IDLE and not in INIT.
- inv_err  out  1  sticky flag: an invalidate targeted a free block.

## Operation
- State per block: an invalid-page counter (PG_W bits, saturating at PAGES_PER_BLOCK) and an allocated bit.
- FSM states are INIT, IDLE, SCAN, MOVE, ERASE and RECLAIM.
- **INIT:** pushes block indices 0..BLOCK_NUM-1, one per cycle, then sets init_done and goes to IDLE. alloc_req is ignored while in INIT.
- **Allocation:** a granted request pops the head, sets that block's allocated bit and loads active_blk. The FIFO cannot overflow because it holds at most BLOCK_NUM entries.
- **Invalidate:**
  - If invalid_blk is allocated, its count is incremented (saturating).
  - If invalid_blk is free, the count is unchanged and inv_err is set.
  - Every accepted invalidate sets the armed flag.
- **IDLE to SCAN:** taken when armed && (free_count <= GC_THRESHOLD || gc_start).
- **SCAN:**
  - Runs for BLOCK_NUM cycles, examining index i on cycle i.
  - A block is a candidate if it is allocated, is not active_blk, and its count is strictly greater than best_cnt. Strict comparison means the lowest index wins ties.
  - best_cnt starts at 0.
  - At the end of the scan: if best_cnt==0, clear armed and return to IDLE. Otherwise latch move_blk and go to MOVE.
- **MOVE:** asserts move_req until move_done, then goes to ERASE. move_done outside MOVE is ignored.
- **ERASE:** asserts erase_req until erase_ack, then goes to RECLAIM. erase_ack outside ERASE is ignored.
- **RECLAIM:** one cycle. Pushes the victim to the FIFO tail, clears its count and allocated bit, then returns to IDLE.
- Allocation remains legal in every state except INIT.

## Timing
- **Reset values:**
  - All outputs are 0; FSM is in INIT; FIFO pointers and all counters are 0; all allocated bits are clear.
  - armed resets to 1.
  - RST mid-operation aborts any handshake; move_req and erase_req drop on the next edge.
- **Init timing:** init_done rises at the edge ending cycle BLOCK_NUM after RST deasserts; free_count then equals BLOCK_NUM.
- **Allocation timing:** a grant is effective at the same edge; free_count and active_blk update on the next cycle.
- **Simultaneous push and pop:** a RECLAIM push and a grant pop in the same cycle leave free_count unchanged. Pointers wrap modulo BLOCK_NUM.
- **Invalidate timing:**
  - An invalidate on cycle t is visible to the scan from cycle t+1.
  - An invalidate during SCAN to an index already passed does not affect the current scan result.
  - Invalidates to the victim during MOVE or ERASE still count, but are cleared at RECLAIM.
- **GC latency:** from IDLE, a full GC takes 1+BLOCK_NUM cycles plus the move wait, plus the erase wait, plus 1 cycle before the victim reappears in the FIFO.

## Test plan
Bench parameters: BLOCK_NUM=8, PAGES_PER_BLOCK=4, GC_THRESHOLD=2.

1. **Reset and allocation order:** release RST, then issue back-to-back alloc_req.
   - Required: init_done at cycle 8 with free_count=8.
   - Required: grants return 0,1,2,… and active_blk tracks each grant.
2. **Saturation and error flag:** invalidate block 0 six times after allocating it, then invalidate free block 7.
   - Required: count for block 0 is 4.
   - Required: inv_err=1 and free_count is unchanged.
3. **Full GC:** allocate blocks 0..5, invalidate block 3 three times, block 1 once and block 5 four times (block 5 is active). Answer move_done after 5 cycles and erase_ack after 3 cycles.
   - Required: move_blk=3 and move_valid_pages=1.
   - Required: erase_blk=3; free_count goes from 2 to 3 after RECLAIM.
   - Required: subsequent grants are 6, 7, 3.
4. **Tie-break and empty scan:**
   - Blocks 2 and 4 each with 2 invalid pages: victim is 2.
   - All counts 0 with gc_start pulsed: FSM returns to IDLE after the scan, armed clears, and no rescan occurs until the next invalidate.
5. **Concurrency and reset mid-handshake:**
   - An alloc during RECLAIM leaves free_count unchanged.
   - RST asserted while in MOVE: move_req=0 next cycle, the FSM re-enters INIT and init_done=0.
